uart_tx_fifo: RTL and testbench

Byte buffer and send sequencer that sits directly upstream of the 8N1 UART transmitter. It accepts bytes from a producer over a valid/ready handshake and stores them in a circular FIFO. It then hands them to the transmitter one at a time through the transmitter's `data`/`send`/`idle` interface, so that back-to-back bytes go out with no lost or duplicated characters.

---
 rtl/uart_tx_fifo.sv | 136 +++++++++++++
 tb/tb_uart_tx_fifo.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_fifo
// Purpose  : Circular byte FIFO feeding an 8N1 transmitter via data/send/idle.
// Revision : 1.0
// ============================================================================
module uart_tx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [WIDTH-1:0]         in_data,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     flush,
  output logic [WIDTH-1:0]         tx_data,
  output logic                     tx_send,
  input  logic                     tx_idle,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     empty,
  output logic                     full
);

  localparam int c_ptr_w = $clog2(DEPTH);
  localparam logic [c_ptr_w:0] c_full_lvl = (c_ptr_w + 1)'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEND = 2'd1,
    S_BUSY = 2'd2
  } state_t;

  logic [WIDTH-1:0]   r_mem [DEPTH];
  logic [c_ptr_w-1:0] r_wr_ptr;
  logic [c_ptr_w-1:0] r_rd_ptr;
  logic [c_ptr_w:0]   r_level;
  state_t             r_state;
  state_t             w_state_nxt;
  logic [WIDTH-1:0]   r_tx_data;
  logic               r_tx_send;
  logic               w_empty;
  logic               w_full;
  logic               w_push;
  logic               w_pop;

  assign w_empty  = (r_level == '0);
  assign w_full   = (r_level == c_full_lvl);
  assign w_push   = in_valid & ~w_full & ~flush;
  assign w_pop    = (r_state == S_IDLE) & ~w_empty & tx_idle & ~flush;

  assign in_ready = ~w_full;
  assign empty    = w_empty;
  assign full     = w_full;
  assign level    = r_level;
  assign tx_data  = r_tx_data;
  assign tx_send  = r_tx_send;

  // Storage needs no reset; contents are only read behind a valid level.
  always_ff @(posedge clock) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= in_data;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      if (w_push && !w_pop) begin
        r_level <= r_level + 1'b1;
      end else if (w_pop && !w_push) begin
        r_level <= r_level - 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // A flush during S_BUSY must not abort the character already on the line.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_pop) begin
          w_state_nxt = S_SEND;
        end
      end
      S_SEND: begin
        if (flush) begin
          w_state_nxt = S_IDLE;
        end else if (tx_idle) begin
          w_state_nxt = S_BUSY;
        end
      end
      S_BUSY: begin
        if (tx_idle) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_tx_send <= 1'b0;
      r_tx_data <= '0;
    end else begin
      r_tx_send <= (w_state_nxt == S_SEND);
      if (w_pop) begin
        r_tx_data <= r_mem[r_rd_ptr];
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx_fifo
// Purpose  : Self-checking bench for uart_tx_fifo with a 4-clock/bit TX model.
// Revision : 1.0
// ============================================================================
module tb_uart_tx_fifo;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] in_data = '0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic       flush = 1'b0;
  logic [7:0] tx_data;
  logic       tx_send;
  logic       tx_idle;
  logic [4:0] level;
  logic       empty;
  logic       full;

  logic       use_model = 1'b0;
  logic       man_idle = 1'b1;
  logic       m_idle;
  int         m_cnt;
  int         n_cap = 0;
  int         m_viol = 0;
  logic [7:0] cap [64];

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic       vld;
    logic [7:0] din;
    logic       idle;
    logic [4:0] lvl;
    logic       snd;
    logic [7:0] dat;
    logic       ful;
  } vec_t;

  vec_t tbl [40];
  int   n_vec = 0;

  uart_tx_fifo #(.WIDTH(8), .DEPTH(16)) dut (
    .clock   (clock),
    .reset   (reset),
    .in_data (in_data),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .flush   (flush),
    .tx_data (tx_data),
    .tx_send (tx_send),
    .tx_idle (tx_idle),
    .level   (level),
    .empty   (empty),
    .full    (full)
  );

  always #5 clock = ~clock;

  assign tx_idle = use_model ? m_idle : man_idle;

  // Transmitter model: registered idle, 10 bits x 4 clocks per character.
  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      m_idle <= 1'b1;
      m_cnt  <= 0;
    end else begin
      if (use_model && tx_send && !m_idle) m_viol <= m_viol + 1;
      if (m_idle) begin
        if (tx_send && use_model) begin
          m_idle     <= 1'b0;
          m_cnt      <= 39;
          cap[n_cap] <= tx_data;
          n_cap      <= n_cap + 1;
        end
      end else if (m_cnt == 0) begin
        m_idle <= 1'b1;
      end else begin
        m_cnt <= m_cnt - 1;
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    in_valid = 1'b0;
    flush = 1'b0;
    use_model = 1'b0;
    man_idle = 1'b1;
    repeat (3) @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    step();
  endtask

  task automatic add(input logic vld, input logic [7:0] din, input logic idle,
                     input logic [4:0] lvl, input logic snd, input logic [7:0] dat,
                     input logic ful);
    tbl[n_vec] = '{vld, din, idle, lvl, snd, dat, ful};
    n_vec++;
  endtask

  initial begin
    // Single byte through IDLE -> SEND -> BUSY -> IDLE
    add(1, 8'hA5, 1, 5'd1, 0, 8'h00, 0);
    add(0, 8'h00, 1, 5'd0, 1, 8'hA5, 0);
    add(0, 8'h00, 1, 5'd0, 0, 8'hA5, 0);
    add(0, 8'h00, 0, 5'd0, 0, 8'hA5, 0);
    add(0, 8'h00, 1, 5'd0, 0, 8'hA5, 0);
    // Fill with transmitter busy; 17th push refused
    for (int i = 0; i < 17; i++)
      add(1, 8'(8'h30 + i), 0, (i >= 15) ? 5'd16 : 5'(i + 1), 0, 8'hA5, (i >= 15));
    // Pop while full blocks the push; SEND stalls until idle returns
    add(1, 8'hEE, 1, 5'd15, 1, 8'h30, 0);
    add(0, 8'h00, 0, 5'd15, 1, 8'h30, 0);
    add(0, 8'h00, 0, 5'd15, 1, 8'h30, 0);
    add(0, 8'h00, 1, 5'd15, 0, 8'h30, 0);
    add(0, 8'h00, 1, 5'd15, 0, 8'h30, 0);
    add(0, 8'h00, 1, 5'd14, 1, 8'h31, 0);
    add(0, 8'h00, 1, 5'd14, 0, 8'h31, 0);

    do_reset();
    chk("reset_level", level, 0);
    chk("reset_empty", empty, 1);
    chk("reset_full", full, 0);
    chk("reset_in_ready", in_ready, 1);
    chk("reset_tx_send", tx_send, 0);
    chk("reset_tx_data", tx_data, 0);

    for (int v = 0; v < n_vec; v++) begin
      in_valid = tbl[v].vld;
      in_data  = tbl[v].din;
      man_idle = tbl[v].idle;
      step();
      chk($sformatf("vec%0d_level", v), level, tbl[v].lvl);
      chk($sformatf("vec%0d_tx_send", v), tx_send, tbl[v].snd);
      chk($sformatf("vec%0d_tx_data", v), tx_data, tbl[v].dat);
      chk($sformatf("vec%0d_full", v), full, tbl[v].ful);
      chk($sformatf("vec%0d_in_ready", v), in_ready, !tbl[v].ful);
      chk($sformatf("vec%0d_empty", v), empty, (tbl[v].lvl == 0));
    end
    in_valid = 1'b0;

    // Flush while in S_SEND with 5 queued bytes and a push offered
    do_reset();
    man_idle = 1'b0;
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1;
      in_data  = 8'(8'h50 + i);
      step();
    end
    in_valid = 1'b0;
    chk("flush_pre_level", level, 6);
    man_idle = 1'b1;
    step();
    chk("flush_send_up", tx_send, 1);
    chk("flush_send_data", tx_data, 8'h50);
    chk("flush_send_level", level, 5);
    man_idle = 1'b0;
    flush = 1'b1;
    in_valid = 1'b1;
    in_data = 8'h99;
    step();
    flush = 1'b0;
    in_valid = 1'b0;
    chk("flush_level", level, 0);
    chk("flush_tx_send", tx_send, 0);
    chk("flush_empty", empty, 1);
    man_idle = 1'b1;
    step();
    chk("flush_after_send", tx_send, 0);
    chk("flush_after_level", level, 0);

    // Flush while in S_BUSY keeps waiting for idle
    in_valid = 1'b1;
    in_data = 8'h61;
    step();
    in_valid = 1'b0;
    step();
    chk("busy_send_61", tx_send, 1);
    chk("busy_data_61", tx_data, 8'h61);
    step();
    chk("busy_entered", tx_send, 0);
    man_idle = 1'b0;
    in_valid = 1'b1;
    in_data = 8'h62;
    step();
    in_data = 8'h63;
    step();
    in_valid = 1'b0;
    chk("busy_queued", level, 2);
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("busy_flush_level", level, 0);
    chk("busy_flush_send", tx_send, 0);
    in_valid = 1'b1;
    in_data = 8'h64;
    step();
    in_valid = 1'b0;
    step();
    chk("busy_wait_send", tx_send, 0);
    man_idle = 1'b1;
    step();
    chk("busy_exit_nopop", tx_send, 0);
    chk("busy_exit_level", level, 1);
    step();
    chk("busy_pop_send", tx_send, 1);
    chk("busy_pop_data", tx_data, 8'h64);
    chk("busy_pop_level", level, 0);

    // Burst of 16 bytes against the transmitter model
    do_reset();
    use_model = 1'b1;
    begin
      int base;
      int viol0;
      int cyc;
      base = n_cap;
      viol0 = m_viol;
      for (int i = 0; i < 16; i++) begin
        chk($sformatf("burst_ready%0d", i), in_ready, 1);
        in_valid = 1'b1;
        in_data = 8'(i + 1);
        step();
      end
      in_valid = 1'b0;
      cyc = 0;
      while (!((n_cap - base) == 16 && m_idle && empty) && cyc < 3000) begin
        step();
        cyc++;
      end
      chk("burst_timeout", (cyc < 3000), 1);
      repeat (50) step();
      chk("burst_count", n_cap - base, 16);
      for (int i = 0; i < 16; i++)
        chk($sformatf("burst_byte%0d", i), cap[base + i], 8'(i + 1));
      chk("burst_send_while_busy", m_viol - viol0, 0);
    end

    // Async reset mid-burst, then no pop until idle rises
    begin
      int cyc;
      int base;
      base = n_cap;
      for (int i = 0; i < 5; i++) begin
        in_valid = 1'b1;
        in_data = 8'(8'hC0 + i);
        step();
      end
      in_valid = 1'b0;
      cyc = 0;
      while (!((n_cap - base) >= 1 && tx_send) && cyc < 500) begin
        step();
        cyc++;
      end
      chk("areset_wait_timeout", (cyc < 500), 1);
      chk("areset_pre_send", tx_send, 1);
      #2;
      man_idle = 1'b0;
      use_model = 1'b0;
      reset = 1'b0;
      #1;
      chk("areset_level", level, 0);
      chk("areset_tx_send", tx_send, 0);
      chk("areset_in_ready", in_ready, 1);
      chk("areset_empty", empty, 1);
      @(negedge clock);
      reset = 1'b1;
      in_valid = 1'b1;
      in_data = 8'hD1;
      step();
      in_valid = 1'b0;
      repeat (5) step();
      chk("areset_hold_send", tx_send, 0);
      chk("areset_hold_level", level, 1);
      man_idle = 1'b1;
      step();
      chk("areset_pop_send", tx_send, 1);
      chk("areset_pop_data", tx_data, 8'hD1);
      chk("areset_pop_level", level, 0);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
